borrow_decrement_subtractor: RTL and testbench

//  Pipelined WIDTH-bit unsigned subtractor: diff = a - b - bin, with borrow out.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/sub4_bla.sv | 30 +++
 rtl/borrow_decrement_subtractor.sv | 148 ++++++++++++++
 tb/tb_borrow_decrement_subtractor.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU package: datapath constants and the subtractor stage-1 register layout.
// The sa/sb sign fields exist only when SUB_OVF_FLAG_EN is defined.
package alu_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned BLK_W   = 4;
  localparam int unsigned SPLIT_W = 16;

  // Stage-1 pipeline register of borrow_decrement_subtractor
  typedef struct packed {
    logic [SPLIT_W-1:0]        lo_diff;
    logic                      lo_borrow;
    logic [DATA_W-SPLIT_W-1:0] hi_raw;
    logic                      hi_borrow;
`ifdef SUB_OVF_FLAG_EN
    logic                      sa;
    logic                      sb;
`endif
  } sub_s1_t;

endpackage

// File: rtl/sub4_bla.sv
// 4-bit borrow-lookahead subtractor: d = x - y - bi, bo = borrow out.
// A bit generates a borrow when x=0,y=1 and propagates the incoming one when x==y.
module sub4_bla
  import alu_pkg::*;
(
  input  logic [BLK_W-1:0] x,
  input  logic [BLK_W-1:0] y,
  input  logic             bi,
  output logic [BLK_W-1:0] d,
  output logic             bo
);

  logic [BLK_W-1:0] g;
  logic [BLK_W-1:0] p;
  logic [BLK_W-1:0] b;

  // Generate/propagate terms, flattened lookahead borrows and difference bits
  always_comb begin
    g    = ~x & y;
    p    = ~(x ^ y);
    b[0] = bi;
    b[1] = g[0] | (p[0] & bi);
    b[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bi);
    b[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bi);
    bo   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & bi);
    d    = x ^ y ^ b;
  end

endmodule

// File: rtl/borrow_decrement_subtractor.sv
// Two-stage pipelined unsigned subtractor, diff = a - b - bin, behind valid/ready.
// Stage 1: lower half borrows from bin, upper half assumes borrow-in 0.
// Stage 2: a per-bit decrement chain folds the lower borrow into the upper half.
// Optional macro SUB_OVF_FLAG_EN adds the signed-overflow output ovf.
module borrow_decrement_subtractor
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W,
  parameter int unsigned SPLIT = SPLIT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NB   = WIDTH / BLK_W;
  localparam int unsigned LO_B = SPLIT / BLK_W;
  localparam int unsigned HI_W = WIDTH - SPLIT;

  // The stage-1 struct is laid out for the package widths
  if (WIDTH != DATA_W || SPLIT != SPLIT_W || (WIDTH % BLK_W) != 0 || (SPLIT % BLK_W) != 0)
  begin : g_bad_cfg
    $error("borrow_decrement_subtractor: WIDTH/SPLIT do not match alu_pkg::sub_s1_t");
  end

  logic [NB-1:0]    blk_bi;
  logic [NB-1:0]    blk_bo;
  logic [WIDTH-1:0] raw;

  for (genvar k = 0; k < NB; k++) begin : g_blk
    if (k == 0) begin : g_first
      assign blk_bi[k] = bin;
    end else if (k == LO_B) begin : g_hi_first
      assign blk_bi[k] = 1'b0;  // upper half starts fresh; corrected in stage 2
    end else begin : g_chain
      assign blk_bi[k] = blk_bo[k-1];
    end
    sub4_bla u_blk (
      .x  (a[k*BLK_W +: BLK_W]),
      .y  (b[k*BLK_W +: BLK_W]),
      .bi (blk_bi[k]),
      .d  (raw[k*BLK_W +: BLK_W]),
      .bo (blk_bo[k])
    );
  end

  sub_s1_t          s1_q, s1_d;
  logic             s1_valid_q, s1_valid_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             s2_ready;

  assign s2_ready = !s2_valid_q | out_ready;
  assign in_ready = !s1_valid_q | s2_ready;

  // Stage-1 next state: capture both half-chains on accept
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_d.lo_diff   = raw[SPLIT-1:0];
        s1_d.lo_borrow = blk_bo[LO_B-1];
        s1_d.hi_raw    = raw[WIDTH-1:SPLIT];
        s1_d.hi_borrow = blk_bo[NB-1];
`ifdef SUB_OVF_FLAG_EN
        s1_d.sa        = a[WIDTH-1];
        s1_d.sb        = b[WIDTH-1];
`endif
      end
    end
  end

  // Decrement chain: hi = hi_raw - lo_borrow; the final borrow is lo_borrow & (hi_raw == 0)
  logic [HI_W:0]   dec_b;
  logic [HI_W-1:0] hi_fix;

  assign dec_b[0] = s1_q.lo_borrow;
  for (genvar i = 0; i < HI_W; i++) begin : g_dec
    assign hi_fix[i]  = s1_q.hi_raw[i] ^ dec_b[i];
    assign dec_b[i+1] = ~s1_q.hi_raw[i] & dec_b[i];
  end

  // Stage-2 next state: result registers advance only when the consumer side has room
  always_comb begin
    s2_valid_d = s2_valid_q;
    diff_d     = diff_q;
    bout_d     = bout_q;
    ovf_d      = ovf_q;
    if (s2_ready) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        diff_d = {hi_fix, s1_q.lo_diff};
        bout_d = s1_q.hi_borrow | dec_b[HI_W];
`ifdef SUB_OVF_FLAG_EN
        ovf_d  = (s1_q.sa ^ s1_q.sb) & (hi_fix[HI_W-1] ^ s1_q.sa);
`else
        ovf_d  = 1'b0;
`endif
      end
    end
  end

  // Pipeline registers with synchronous flush
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      diff_q     <= '0;
      bout_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      s2_valid_q <= s2_valid_d;
      diff_q     <= diff_d;
      bout_q     <= bout_d;
      ovf_q      <= ovf_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
`ifdef SUB_OVF_FLAG_EN
  assign ovf       = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_borrow_decrement_subtractor.sv
// Scoreboard bench for borrow_decrement_subtractor; also checks ovf when SUB_OVF_FLAG_EN is set.
module tb_borrow_decrement_subtractor;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  always #5 clk = ~clk;

  borrow_decrement_subtractor #(
    .WIDTH (W),
    .SPLIT (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
`ifdef SUB_OVF_FLAG_EN
    ,
    .ovf       (ovf)
`endif
  );

`ifndef SUB_OVF_FLAG_EN
  assign ovf = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
    int           stamp;
  } exp_t;

  exp_t         sb_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           n_pop = 0;
  bit           chk_lat = 0;
  bit           stall_prev = 0;
  logic [W-1:0] hold_diff;
  logic         hold_bout;
  logic         hold_ovf;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
    exp_t       e;
    logic [W:0] r;
    r    = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
    e.d  = r[W-1:0];
    e.bo = r[W];
`ifdef SUB_OVF_FLAG_EN
    e.ov = (ma[W-1] ^ mb[W-1]) & (r[W-1] ^ ma[W-1]);
`else
    e.ov = 1'b0;
`endif
    e.stamp = cyc;
    return e;
  endfunction

  // One cycle: drive at negedge, then settle and score both handshakes for the coming edge
  task automatic step(input logic v, input logic [W-1:0] ta, input logic [W-1:0] tb,
                      input logic tbin, input logic ordy, input logic r, output bit acc);
    exp_t e;
    @(negedge clk);
    rst = r; in_valid = v; a = ta; b = tb; bin = tbin; out_ready = ordy;
    #1;
    acc = 0;
    if (stall_prev) begin
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_diff", 64'(diff), 64'(hold_diff));
      chk("stall_bout", 64'(bout), 64'(hold_bout));
`ifdef SUB_OVF_FLAG_EN
      chk("stall_ovf", 64'(ovf), 64'(hold_ovf));
`endif
    end
    if (!r) begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("spurious_out", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          n_pop++;
          chk("diff", 64'(diff), 64'(e.d));
          chk("bout", 64'(bout), 64'(e.bo));
`ifdef SUB_OVF_FLAG_EN
          chk("ovf", 64'(ovf), 64'(e.ov));
`endif
          if (chk_lat) chk("latency", 64'(cyc - e.stamp), 64'd2);
        end
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(model(ta, tb, tbin));
        acc = 1;
      end
    end
    stall_prev = !r && out_valid && !out_ready;
    hold_diff  = diff;
    hold_bout  = bout;
    hold_ovf   = ovf;
    cyc++;
  endtask

  task automatic drain(input string tag, input int budget);
    bit acc;
    int n = budget;
    while (sb_q.size() > 0 && n > 0) begin
      step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, acc);
      n--;
    end
    chk(tag, 64'(sb_q.size()), 64'd0);
  endtask

  logic [W-1:0] da [8] = '{32'd5, 32'h0000_0000, 32'h0001_0000, 32'h8000_0000,
                           32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_FFFF};
  logic [W-1:0] db [8] = '{32'd3, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001,
                           32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_FFFF};
  logic         dbin [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit           acc;
    int           sent;
    int           pi;
    int           bud;
    int           pop0;
    logic [W-1:0] ra [16];
    logic [W-1:0] rb [16];
    logic         rbin [16];
    logic         ordy;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b1;
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, acc);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, acc);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, acc);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_diff", 64'(diff), 64'd0);
    chk("rst_bout", 64'(bout), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Directed vectors, full throughput, fixed latency
    chk_lat = 1;
    for (int i = 0; i < 8; i++) begin
      acc = 0;
      for (int t = 0; t < 4 && !acc; t++) step(1'b1, da[i], db[i], dbin[i], 1'b1, 1'b0, acc);
      chk("dir_accept", 64'(acc), 64'd1);
    end
    drain("dir_drain", 10);
    chk_lat = 0;

    // Random stream under out_ready pattern 1,0,0,1
    for (int i = 0; i < 16; i++) begin
      ra[i] = $urandom; rb[i] = $urandom; rbin[i] = 1'($urandom_range(1));
    end
    ra[3] = rb[3];
    sent = 0; pi = 0; bud = 200; pop0 = n_pop;
    while ((sent < 16 || sb_q.size() > 0) && bud > 0) begin
      ordy = (pi % 4 == 1 || pi % 4 == 2) ? 1'b0 : 1'b1;
      step(sent < 16, ra[sent < 16 ? sent : 0], rb[sent < 16 ? sent : 0],
           rbin[sent < 16 ? sent : 0], ordy, 1'b0, acc);
      if (acc) sent++;
      pi++; bud--;
    end
    chk("rand_drain", 64'(sb_q.size()), 64'd0);
    chk("rand_count", 64'(n_pop - pop0), 64'd16);

    // Fill both stages, stall, then flush with reset
    step(1'b1, 32'd100, 32'd1, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 32'd200, 32'd2, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 32'd300, 32'd3, 1'b0, 1'b0, 1'b0, acc);
    chk("fill_in_ready", 64'(in_ready), 64'd0);
    chk("fill_out_valid", 64'(out_valid), 64'd1);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
    sb_q.delete();
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, acc);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_diff", 64'(diff), 64'd0);
    chk("flush_bout", 64'(bout), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, acc);
      chk("flush_no_stale", 64'(out_valid), 64'd0);
    end

    // Post-flush operation still works
    step(1'b1, 32'd7, 32'd9, 1'b1, 1'b1, 1'b0, acc);
    chk("post_accept", 64'(acc), 64'd1);
    drain("post_drain", 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
